// File: rtl/ysyx_23060236_axi_rd_slave.sv
// AXI4-subset read-only responder over an internal word array with preload side port.
// Optional error responses are enabled by defining YSYX_23060236_AXI_RD_SLAVE_ERR_EN.
module ysyx_23060236_axi_rd_slave #(
    parameter int          AW      = 12,
    parameter logic [31:0] BASE    = 32'h30000000,
    parameter int          LATENCY = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   araddr,
    input  logic          arvalid,
    output logic          arready,
    input  logic [1:0]    arburst,
    input  logic [3:0]    arlen,
    output logic [31:0]   rdata,
    output logic [1:0]    rresp,
    output logic          rlast,
    output logic          rvalid,
    input  logic          rready,
    input  logic          pre_wen,
    input  logic [AW-1:0] pre_waddr,
    input  logic [31:0]   pre_wdata
);

    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [29:0]   addr_reg, next_addr, load_addr, word_off;
    logic [3:0]    len_reg, beat_reg;
    logic [1:0]    burst_reg;
    logic [LW-1:0] lat_reg;
    logic [31:0]   rdata_reg, load_data;
    logic          rlast_reg;
    logic          wrap_ok;
    logic [AW-1:0] load_idx;
    logic          unused_bits;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (arvalid) state_next = S_WAIT;
            S_WAIT:  if (lat_reg == '0) state_next = S_BURST;
            S_BURST: if (rready && rlast_reg) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        arready = (state_reg == S_IDLE);
        rvalid  = (state_reg == S_BURST);
    end

    // WRAP only for power-of-two lengths; len_reg then doubles as the wrap mask
    assign wrap_ok = (burst_reg == 2'b10) &&
                     ((len_reg == 4'd1) || (len_reg == 4'd3) || (len_reg == 4'd7) || (len_reg == 4'd15));

    always_comb begin
        next_addr = addr_reg + 30'd1;
        if (burst_reg == 2'b00)
            next_addr = addr_reg;
        else if (wrap_ok)
            next_addr = (addr_reg & ~{26'd0, len_reg}) | ((addr_reg + 30'd1) & {26'd0, len_reg});
    end

    // WAIT loads the first beat from the captured address; BURST loads the advanced one
    assign load_addr = (state_reg == S_WAIT) ? addr_reg : next_addr;
    assign word_off  = load_addr - BASE[31:2];
    assign load_idx  = word_off[AW-1:0];

`ifdef YSYX_23060236_AXI_RD_SLAVE_ERR_EN
    logic       load_oob;
    logic [1:0] load_resp, rresp_reg;
    assign load_oob    = |word_off[29:AW];
    assign load_resp   = (load_oob || burst_reg == 2'b11) ? 2'b10 : 2'b00;
    assign load_data   = load_oob ? 32'd0 : mem[load_idx];
    assign rresp       = rresp_reg;
    assign unused_bits = ^araddr[1:0];
`else
    assign load_data   = mem[load_idx];
    assign rresp       = 2'b00;
    assign unused_bits = ^{araddr[1:0], word_off[29:AW]};
`endif

    always_ff @(posedge clock) begin
        if (pre_wen) mem[pre_waddr] <= pre_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_reg  <= '0;
            len_reg   <= '0;
            burst_reg <= '0;
            beat_reg  <= '0;
            lat_reg   <= '0;
            rdata_reg <= '0;
            rlast_reg <= 1'b0;
`ifdef YSYX_23060236_AXI_RD_SLAVE_ERR_EN
            rresp_reg <= 2'b00;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (arvalid) begin
                        addr_reg  <= araddr[31:2];
                        len_reg   <= arlen;
                        burst_reg <= arburst;
                        beat_reg  <= '0;
                        lat_reg   <= LW'(LATENCY);
                    end
                end
                S_WAIT: begin
                    if (lat_reg == '0) begin
                        rdata_reg <= load_data;
                        rlast_reg <= (len_reg == 4'd0);
`ifdef YSYX_23060236_AXI_RD_SLAVE_ERR_EN
                        rresp_reg <= load_resp;
`endif
                    end else begin
                        lat_reg <= lat_reg - 1'b1;
                    end
                end
                S_BURST: begin
                    if (rready) begin
                        if (rlast_reg) begin
                            rlast_reg <= 1'b0;
                        end else begin
                            addr_reg  <= next_addr;
                            beat_reg  <= beat_reg + 4'd1;
                            rdata_reg <= load_data;
                            rlast_reg <= ((beat_reg + 4'd1) == len_reg);
`ifdef YSYX_23060236_AXI_RD_SLAVE_ERR_EN
                            rresp_reg <= load_resp;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign rlast = rlast_reg;

endmodule

// File: doc/ysyx_23060236_axi_rd_slave.md
Name: ysyx_23060236_axi_rd_slave

Overview:
AXI4-subset read-only responder backed by an internal word array. It serves single-beat and burst reads from a read master such as the instruction-fetch unit, which issues 8-beat INCR line fills. It sits at the slave end of the fetch/load AR/R channels in simulation and FPGA builds, replacing the external memory model. It has a configurable initial access latency, full-throughput beats, and a side port for preloading the array.

Parameters:
AW, 12, word-address width; array depth = 2^AW 32-bit words
BASE, 32'h30000000, byte address mapped to word 0
LATENCY, 2, cycles from AR handshake to first rvalid, minus 1 (0 gives first rvalid on the cycle after the handshake)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, ACTIVE-LOW (0 = reset)
araddr  in  32  byte address; bits [1:0] ignored
arvalid  in  1  AR valid
arready  out  1  AR ready
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
arlen  in  4  beats minus 1
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
pre_wen  in  1  preload write enable
pre_waddr  in  AW  preload word index
pre_wdata  in  32  preload data

Behaviour:
- FSM states:
  - IDLE: arready=1, rvalid=0.
  - WAIT: latency counter running.
  - BURST: rvalid=1.
- Reset (reset=0, async) values:
  - State IDLE, arready=1, rvalid=0, rlast=0, rresp=00, rdata=0, counters 0.
  - Array contents are not reset.
- AR capture (arvalid&arready in IDLE):
  - Latch araddr[31:2], arlen, arburst.
  - Beat counter = 0, latency counter = LATENCY.
  - Go to WAIT. arready drops on the next cycle; only one transaction is outstanding.
- WAIT:
  - Decrement the latency counter each cycle.
  - When it reaches 0: load rdata from the current beat address, set rvalid=1, set rlast=(arlen==0), go to BURST.
  - With LATENCY=0, rvalid rises exactly one cycle after the AR handshake.
- BURST:
  - rdata, rresp and rlast are held stable while rvalid&~rready.
  - On rvalid&rready with rlast=0: on the same edge, advance the address, load the next word, increment the beat counter, and keep rvalid=1. This gives one beat per cycle with no bubbles.
  - On rvalid&rready with rlast=1: clear rvalid and rlast and return to IDLE (arready=1 next cycle). A new AR is accepted no earlier than the cycle after the last beat.
  - rlast = (beat counter == arlen).
- Address advance (word granularity):
  - FIXED: address unchanged.
  - INCR: +1 word. Wraps modulo 2^30 words; no 4 KB boundary check.
  - WRAP: the low log2(arlen+1) bits increment modulo (arlen+1); the upper bits are fixed. Legal arlen values are 1, 3, 7, 15. Any other arlen is treated as INCR.
  - 11 (reserved): treated as INCR.
- Array index = ((addr - BASE) >> 2) mod 2^AW. rresp = 00 unless the optional feature is enabled.
- Preload:
  - pre_wen writes the array on the clock edge.
  - If it targets the word being loaded into rdata on the same edge, rdata receives the OLD value.
  - Already-presented rdata never changes.
- Reset asserted mid-burst:
  - Outputs go to reset values immediately.
  - After release the block is in IDLE; the aborted burst is not resumed.

Optional Feature:
Macro YSYX_23060236_AXI_RD_SLAVE_ERR_EN.
- Defined:
  - A beat whose byte address lies outside [BASE, BASE + 4*2^AW) returns rresp=10 and rdata=0.
  - A transaction with arburst=11 returns rresp=10 on every beat.
  - Beat count and rlast are unchanged; the burst always completes.
- Undefined: out-of-range addresses alias modulo depth, rresp is always 00, and no extra logic is generated.

Test Plan:
1. Preload words 8..15 with 0x100..0x107. LATENCY=2, rready=1. AR araddr=0x30000020, INCR, arlen=7. Required: rvalid first high 3 cycles after the handshake; 8 consecutive beats 0x100..0x107; rlast only on beat 8; arready=1 the cycle after.
2. Same burst with rready toggled 1,0,0,1,... Required: rdata/rlast held during stalls, no beat skipped or duplicated, order 0x100..0x107.
3. WRAP, arlen=3, araddr=0x30000028 (word 10). Required: data from words 10, 11, 8, 9; rlast on the 4th beat.
4. FIXED, arlen=2, araddr=0x30000004 with word 1=0xDEADBEEF. pre_wen writes word 1=0x1 during beat 1 while rready=0. Required: beat 1=0xDEADBEEF held; beats 2-3=0x1.
5. Pull reset low in the middle of beat 4 of an 8-beat INCR. Required: rvalid and rlast low immediately, arready=1. A new single read (arlen=0) after release returns the correct word with rlast=1.
6. With ERR_EN defined and AW=12: INCR arlen=1 at 0x30003FFC. Required: beat 1 rresp=00 with valid data; beat 2 rresp=10, rdata=0, rlast=1. Without ERR_EN: beat 2 returns word 0 with rresp=00.
